fmap_stream_tx: RTL and testbench

Synthesizable feature-map transmitter. It reads one complete multi-channel Q15 feature map from a synchronous-read buffer RAM. It emits the map as a valid/ready pixel stream in channel-major raster order, with row, map and frame markers. It sits between the conv2d output buffer and the streaming 2x2/stride-2 max-pool stage, and replaces file-based hand-off with a hardware handshake.

---
 rtl/fmap_stream_tx_if.sv | 42 ++++
 rtl/fmap_stream_tx.sv | 181 ++++++++++++++++++
 tb/tb_fmap_stream_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fmap_stream_tx_if.sv
// fmap_stream_tx_if
// Bundles the two buses of the feature-map transmitter:
//   - buffer RAM read port: mem_rd_en, mem_addr (to RAM), mem_rdata (from RAM,
//     valid exactly one cycle after mem_rd_en)
//   - pixel stream: m_valid, m_data, m_chan, m_eol, m_eom, m_last (to sink),
//     m_ready (from sink)
// Stream handshake: a beat transfers on every rising clk edge where
// m_valid & m_ready are both high. Once m_valid is raised it stays high, and
// all m_* payload fields stay stable, until that transfer happens. m_ready may
// change freely and does not depend on m_valid.
// Modports: master = the transmitter, slave = RAM/stream sink side.
interface fmap_stream_tx_if #(
    parameter int DATA_W = 25,
    parameter int ADDR_W = 14,
    parameter int CHAN_W = 4
);
    logic                     mem_rd_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [DATA_W-1:0] mem_rdata;

    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic [CHAN_W-1:0]        m_chan;
    logic                     m_eol;
    logic                     m_eom;
    logic                     m_last;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output m_valid, m_data, m_chan, m_eol, m_eom, m_last,
        input  m_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  m_valid, m_data, m_chan, m_eol, m_eom, m_last,
        output m_ready
    );
endinterface

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx
// Reads a complete CHANNELS x HEIGHT_IN x WIDTH_IN Q15 feature map from a
// synchronous-read buffer RAM and emits it as a valid/ready pixel stream in
// channel-major raster order with row (eol), map (eom) and frame (last)
// markers.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   start      one-cycle request, only honoured in IDLE
//   busy       high while the transfer runs (RUN/DRAIN)
//   done       one-cycle pulse after the final beat is accepted
//   fsm_state  current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//   bus        RAM read port + pixel stream (fmap_stream_tx_if.master)
module fmap_stream_tx #(
    parameter int WIDTH_IN = 32,
    parameter int HEIGHT_IN = 32,
    parameter int CHANNELS = 16,
    parameter int DATA_W = 25,
    parameter int ADDR_W = 14,
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [1:0]          fsm_state,
    fmap_stream_tx_if.master    bus
);

    localparam int X_W = (WIDTH_IN > 1) ? $clog2(WIDTH_IN) : 1;
    localparam int Y_W = (HEIGHT_IN > 1) ? $clog2(HEIGHT_IN) : 1;
    localparam logic [X_W-1:0]    X_MAX = X_W'(WIDTH_IN - 1);
    localparam logic [Y_W-1:0]    Y_MAX = Y_W'(HEIGHT_IN - 1);
    localparam logic [CHAN_W-1:0] C_MAX = CHAN_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Sideband computed at read-issue time; travels with the read.
    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic              eol;
        logic              eom;
        logic              last;
    } side_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] data;
        logic [CHAN_W-1:0]        chan;
        logic                     eol;
        logic                     eom;
        logic                     last;
    } beat_t;

    state_t state_q, state_d;

    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [CHAN_W-1:0] c_q;
    logic [ADDR_W-1:0] addr_q;

    // A read presented last cycle; its data is on mem_rdata this cycle.
    logic  fly_q;
    side_t fly_side_q;

    beat_t      fifo_mem [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    beat_t      head;

    logic       x_last, y_last, c_last, map_end, all_end;
    logic       push, pop, issue;
    logic [2:0] pend;

    assign head    = fifo_mem[rd_ptr_q];
    assign push    = fly_q;
    assign pop     = (count_q != 2'd0) && bus.m_ready;

    assign x_last  = (x_q == X_MAX);
    assign y_last  = (y_q == Y_MAX);
    assign c_last  = (c_q == C_MAX);
    assign map_end = x_last && y_last;
    assign all_end = map_end && c_last;

    // Entries that will still be held once this cycle's pop is taken into
    // account. Crediting the pop lets a new read issue while the FIFO head
    // drains, which is what sustains one beat per cycle with only two
    // entries; without a pop the total never exceeds two.
    assign pend  = {1'b0, count_q} + {2'b00, fly_q} - {2'b00, pop};
    assign issue = (state_q == RUN) && (pend < 3'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (issue && all_end) state_d = DRAIN;
            DRAIN:   if (pop && head.last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            c_q         <= '0;
            addr_q      <= '0;
            fly_q       <= 1'b0;
            fly_side_q  <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && start) begin
                x_q    <= '0;
                y_q    <= '0;
                c_q    <= '0;
                addr_q <= '0;
            end else if (issue) begin
                // Raster order makes the address a plain running count.
                addr_q <= all_end ? '0 : addr_q + ADDR_W'(1);
                if (x_last) begin
                    x_q <= '0;
                    if (y_last) begin
                        y_q <= '0;
                        c_q <= c_last ? '0 : c_q + CHAN_W'(1);
                    end else begin
                        y_q <= y_q + Y_W'(1);
                    end
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end

            fly_q <= issue;
            if (issue) begin
                fly_side_q <= '{chan: c_q, eol: x_last, eom: map_end, last: all_end};
            end

            if (push) begin
                fifo_mem[wr_ptr_q] <= {bus.mem_rdata, fly_side_q};
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign fsm_state = state_q;

    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = addr_q;

    assign bus.m_valid = (count_q != 2'd0);
    assign bus.m_data  = head.data;
    assign bus.m_chan  = head.chan;
    assign bus.m_eol   = head.eol;
    assign bus.m_eom   = head.eom;
    assign bus.m_last  = head.last;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// tb_fmap_stream_tx
// Directed bench for fmap_stream_tx with a 4x2x2 map. RAM word n holds n,
// except address 5 which holds -1 (25'h1FFFFFF).
module tb_fmap_stream_tx;

    localparam int W = 4;
    localparam int H = 2;
    localparam int C = 2;
    localparam int DW = 25;
    localparam int AW = 14;
    localparam int CW = 1;
    localparam int N = W * H * C;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic [1:0] fsm_state;

    fmap_stream_tx_if #(.DATA_W(DW), .ADDR_W(AW), .CHAN_W(CW)) bus ();

    fmap_stream_tx #(
        .WIDTH_IN(W), .HEIGHT_IN(H), .CHANNELS(C), .DATA_W(DW), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .fsm_state(fsm_state),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [DW-1:0] ram [N];
    initial begin
        for (int i = 0; i < N; i++) ram[i] = DW'(i);
        ram[5] = 25'h1FFFFFF;
    end
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr[3:0]];
    end

    // ---------------- checker ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [28:0] exp_q[$];
    int beats;
    int done_cnt;
    int cyc;
    int first_hs_cyc;
    int last_hs_cyc;
    int issued;
    int accepted;
    logic stall_prev;
    logic [29:0] prev_out;

    function automatic logic [28:0] exp_beat(input int i);
        logic [DW-1:0] d;
        logic [CW-1:0] ch;
        d  = (i == 5) ? 25'h1FFFFFF : DW'(i);
        ch = CW'(i / (W * H));
        return {d, ch, (i % W) == W - 1, (i % (W * H)) == W * H - 1, i == N - 1};
    endfunction

    task automatic fill_expected();
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(exp_beat(i));
    endtask

    initial begin
        beats = 0; done_cnt = 0; cyc = 0; first_hs_cyc = 0; last_hs_cyc = 0;
        issued = 0; accepted = 0; stall_prev = 1'b0; prev_out = '0;
    end

    always @(negedge clk) begin
        logic [29:0] cur;
        cyc++;
        cur = {bus.m_valid, bus.m_data, bus.m_chan, bus.m_eol, bus.m_eom, bus.m_last};
        if (!rst) begin
            issued = 0;
            accepted = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check_val("stall_stable", 32'(cur), 32'(prev_out));
            if (bus.mem_rd_en) issued++;
            if (bus.m_valid && bus.m_ready) begin
                accepted++;
                if (beats == 0) first_hs_cyc = cyc;
                if (bus.m_last) last_hs_cyc = cyc;
                if (exp_q.size() == 0) check_val("extra_beat", 32'd1, 32'd0);
                else check_val($sformatf("beat%0d", beats), 32'(cur[28:0]), 32'(exp_q.pop_front()));
                beats++;
            end
            if (bus.mem_rd_en) check_val("outstanding_le2", 32'(issued - accepted <= 2), 32'd1);
            if (done) begin
                done_cnt++;
                check_val("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            prev_out = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string p);
        check_val({p, "_busy"}, 32'(busy), 32'd0);
        check_val({p, "_done"}, 32'(done), 32'd0);
        check_val({p, "_state"}, 32'(fsm_state), 32'd0);
        check_val({p, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        check_val({p, "_addr"}, 32'(bus.mem_addr), 32'd0);
        check_val({p, "_stream"},
                  32'({bus.m_valid, bus.m_data, bus.m_chan, bus.m_eol, bus.m_eom, bus.m_last}),
                  32'd0);
    endtask

    // mode 0: ready high, latency/throughput checks
    // mode 1: ready toggling, held low 5 cycles at beat 6
    // mode 2: ready high, extra start pulse at beat 4
    task automatic run_xfer(input int mode, input string p);
        int hold;
        logic held;
        logic pulsed;
        hold = 0; held = 1'b0; pulsed = 1'b0;
        fill_expected();
        beats = 0;
        done_cnt = 0;
        bus.m_ready = 1'b1;
        start = 1'b1;
        wait_cycle();
        start = 1'b0;
        if (mode == 0) begin
            check_val("lat_busy", 32'(busy), 32'd1);
            check_val("lat_rd_en", 32'(bus.mem_rd_en), 32'd1);
            check_val("lat_valid_e0", 32'(bus.m_valid), 32'd0);
            wait_cycle();
            check_val("lat_valid_e1", 32'(bus.m_valid), 32'd0);
            wait_cycle();
            check_val("lat_valid_e2", 32'(bus.m_valid), 32'd1);
        end
        for (int n = 0; n < 300 && done_cnt == 0; n++) begin
            if (mode == 1) begin
                if (beats >= 6 && !held) begin
                    hold = 5;
                    held = 1'b1;
                end
                if (hold > 0) begin
                    bus.m_ready = 1'b0;
                    hold--;
                end else begin
                    bus.m_ready = ~bus.m_ready;
                end
            end
            if (mode == 2) begin
                if (beats == 4 && !pulsed) begin
                    start = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            wait_cycle();
        end
        start = 1'b0;
        bus.m_ready = 1'b1;
        for (int n = 0; n < 6; n++) wait_cycle();
        check_val({p, "_beats"}, 32'(beats), 32'(N));
        check_val({p, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check_val({p, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        check_val({p, "_idle_busy"}, 32'(busy), 32'd0);
        if (mode == 0) check_val("throughput", 32'(last_hs_cyc - first_hs_cyc), 32'(N - 1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        start = 1'b0;
        bus.m_ready = 1'b0;
        wait_cycle();
        wait_cycle();
        check_reset_vals("reset");
        rst = 1'b1;
        wait_cycle();

        run_xfer(0, "basic");
        run_xfer(1, "bp");
        run_xfer(2, "start_busy");

        // Abort at beat 9, then restart from address 0.
        fill_expected();
        beats = 0;
        done_cnt = 0;
        bus.m_ready = 1'b1;
        start = 1'b1;
        wait_cycle();
        start = 1'b0;
        for (int n = 0; n < 100 && beats < 9; n++) wait_cycle();
        check_val("abort_reached_beat9", 32'(beats), 32'd9);
        rst = 1'b0;
        wait_cycle();
        check_reset_vals("abort");
        rst = 1'b1;
        exp_q.delete();
        wait_cycle();
        check_val("abort_no_done", 32'(done_cnt), 32'd0);
        run_xfer(0, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
